// File: rtl/sync_fifo_param_if.sv
// Write/read handshake and status bundle between sync_fifo_param and its user.
interface sync_fifo_param_if #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CNT_W-1:0]      count;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, wr_ack, overflow, underflow,
        input  full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, wr_ack, overflow, underflow,
        output full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, almost-full/empty thresholds and
// optional first-word-fall-through read port.
module sync_fifo_param #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int unsigned AE_LEVEL   = 1,
    parameter int unsigned FWFT       = 0
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_param_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  wr_ack_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic full_c;
    logic empty_c;
    logic wr_go_c;
    logic rd_go_c;

    // Acceptance is decided on the occupancy at the start of the cycle.
    always_comb begin
        full_c  = (count_q == DEPTH_CNT);
        empty_c = (count_q == '0);
        wr_go_c = bus.wr_en && !full_c;
        rd_go_c = bus.rd_en && !empty_c;
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ack_q    <= wr_go_c;
            overflow_q  <= bus.wr_en && full_c;
            underflow_q <= bus.rd_en && empty_c;
            if (wr_go_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_go_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (wr_go_c && !rd_go_c) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!wr_go_c && rd_go_c) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage is never cleared; occupancy tracking keeps stale words unreachable.
    always_ff @(posedge clk) begin
        if (!rst && wr_go_c) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [FIFO_WIDTH-1:0] data_out_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out_q <= '0;
                end else if (rd_go_c) begin
                    data_out_q <= mem[rd_ptr];
                end
            end

            assign bus.data_out = data_out_q;
        end else begin : g_fwft_read
            // Head word is presented as soon as it exists; rd_en consumes it.
            assign bus.data_out = empty_c ? '0 : mem[rd_ptr];
        end
    endgenerate

    assign bus.wr_ack      = wr_ack_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.count       = count_q;
    assign bus.full        = full_c;
    assign bus.empty       = empty_c;
    assign bus.almostfull  = (count_q >= AF_CNT) && !full_c;
    assign bus.almostempty = (count_q <= AE_CNT) && !empty_c;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: a registered-read depth-8 FIFO and a FWFT depth-5 FIFO
// driven by directed and random traffic against a queue-based reference.
module tb_sync_fifo_param;
    localparam int unsigned W   = 16;
    localparam int unsigned D0  = 8;
    localparam int unsigned D1  = 5;
    localparam int unsigned AF1 = 3;
    localparam int unsigned AE1 = 2;

    typedef logic [W-1:0] word_t;

    typedef struct packed {
        logic       wr_ack;
        logic       overflow;
        logic       underflow;
        logic       full;
        logic       empty;
        logic       almostfull;
        logic       almostempty;
        logic [7:0] count;
        word_t      data_out;
    } obs_t;

    logic clk;
    logic rst0;
    logic rst1;

    sync_fifo_param_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D0)) if0 ();
    sync_fifo_param_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D1)) if1 ();

    sync_fifo_param #(
        .FIFO_WIDTH(W), .FIFO_DEPTH(D0)
    ) u_dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (if0.slave)
    );

    sync_fifo_param #(
        .FIFO_WIDTH(W), .FIFO_DEPTH(D1), .AF_LEVEL(AF1), .AE_LEVEL(AE1), .FWFT(1)
    ) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    word_t mq   [2][$];
    obs_t  expq [2][$];
    word_t held [2];
    int    n_pass  = 0;
    int    n_total = 0;

    // Reference: a queue of stored words plus the last word read out.
    function automatic void model_step(int i, logic r, logic we, logic re, word_t d);
        int   dep = (i == 0) ? int'(D0) : int'(D1);
        int   af  = (i == 0) ? int'(D0) - 1 : int'(AF1);
        int   ae  = (i == 0) ? 1 : int'(AE1);
        int   n;
        obs_t e;
        e = '0;
        if (r) begin
            mq[i].delete();
            held[i] = '0;
        end else begin
            n           = mq[i].size();
            e.wr_ack    = we && (n < dep);
            e.overflow  = we && (n == dep);
            e.underflow = re && (n == 0);
            if (re && n > 0) held[i] = mq[i].pop_front();
            if (we && n < dep) mq[i].push_back(d);
        end
        n             = mq[i].size();
        e.count       = 8'(n);
        e.full        = (n == dep);
        e.empty       = (n == 0);
        e.almostfull  = (n >= af) && (n < dep);
        e.almostempty = (n <= ae) && (n > 0);
        if (i == 1) e.data_out = (n > 0) ? mq[i][0] : '0;
        else        e.data_out = held[i];
        expq[i].push_back(e);
    endfunction

    function automatic void chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", nm, i, act, exp, $time);
    endfunction

    function automatic obs_t sample(int i);
        obs_t a;
        if (i == 0) begin
            a = {if0.wr_ack, if0.overflow, if0.underflow, if0.full, if0.empty,
                 if0.almostfull, if0.almostempty, 8'(if0.count), if0.data_out};
        end else begin
            a = {if1.wr_ack, if1.overflow, if1.underflow, if1.full, if1.empty,
                 if1.almostfull, if1.almostempty, 8'(if1.count), if1.data_out};
        end
        return a;
    endfunction

    function automatic void cmp(int i, obs_t a, obs_t e);
        chk("wr_ack",      i, 32'(a.wr_ack),      32'(e.wr_ack));
        chk("overflow",    i, 32'(a.overflow),    32'(e.overflow));
        chk("underflow",   i, 32'(a.underflow),   32'(e.underflow));
        chk("full",        i, 32'(a.full),        32'(e.full));
        chk("empty",       i, 32'(a.empty),       32'(e.empty));
        chk("almostfull",  i, 32'(a.almostfull),  32'(e.almostfull));
        chk("almostempty", i, 32'(a.almostempty), 32'(e.almostempty));
        chk("count",       i, 32'(a.count),       32'(e.count));
        chk("data_out",    i, 32'(a.data_out),    32'(e.data_out));
    endfunction

    // Monitor: one expected observation per driven cycle, checked after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (expq[i].size() > 0) cmp(i, sample(i), expq[i].pop_front());
            end
        end
    end

    task automatic cycle(input logic [1:0] r, input logic [1:0] we, input logic [1:0] re,
                         input word_t d0, input word_t d1);
        @(negedge clk);
        rst0         = r[0];
        if0.wr_en    = we[0];
        if0.rd_en    = re[0];
        if0.data_in  = d0;
        rst1         = r[1];
        if1.wr_en    = we[1];
        if1.rd_en    = re[1];
        if1.data_in  = d1;
        model_step(0, r[0], we[0], re[0], d0);
        model_step(1, r[1], we[1], re[1], d1);
    endtask

    initial begin
        logic [1:0] r;
        logic [1:0] we;
        logic [1:0] re;
        int unsigned wprob;

        rst0 = 1'b1;
        rst1 = 1'b1;
        if0.wr_en = 1'b0; if0.rd_en = 1'b0; if0.data_in = '0;
        if1.wr_en = 1'b0; if1.rd_en = 1'b0; if1.data_in = '0;

        cycle(2'b11, 2'b00, 2'b00, '0, '0);

        // Fill the depth-8 FIFO with 1..8, then one write too many.
        for (int k = 1; k <= 9; k++) cycle(2'b00, 2'b01, 2'b00, word_t'(k), '0);
        // Drain it, then one read too many.
        for (int k = 0; k < 9; k++) cycle(2'b00, 2'b00, 2'b01, '0, '0);

        // Simultaneous write+read on empty, fill up, then simultaneous on full.
        cycle(2'b00, 2'b01, 2'b01, 16'hA5A5, '0);
        for (int k = 0; k < 7; k++) cycle(2'b00, 2'b01, 2'b00, word_t'($urandom), '0);
        cycle(2'b00, 2'b01, 2'b01, 16'hA5A5, '0);

        // Reset wins over a concurrent write at count 4.
        cycle(2'b01, 2'b00, 2'b00, '0, '0);
        for (int k = 0; k < 4; k++) cycle(2'b00, 2'b01, 2'b00, word_t'(16'h0100 + k), '0);
        cycle(2'b01, 2'b01, 2'b00, 16'hBEEF, '0);
        cycle(2'b00, 2'b00, 2'b01, '0, '0);

        // FWFT: a single word falls through, then is consumed.
        cycle(2'b00, 2'b10, 2'b00, '0, 16'h1234);
        cycle(2'b00, 2'b00, 2'b00, '0, '0);
        cycle(2'b00, 2'b00, 2'b10, '0, '0);

        // FWFT depth 5: hold count at 2 across pointer wrap.
        cycle(2'b00, 2'b10, 2'b00, '0, 16'h2000);
        cycle(2'b00, 2'b10, 2'b00, '0, 16'h2001);
        for (int k = 2; k < 14; k++) cycle(2'b00, 2'b10, 2'b10, '0, word_t'(16'h2000 + k));
        for (int k = 0; k < 3; k++) cycle(2'b00, 2'b00, 2'b10, '0, '0);

        // Random traffic with phases biased toward filling, draining and mixing.
        for (int c = 0; c < 3000; c++) begin
            case ((c / 150) % 3)
                0:       wprob = 80;
                1:       wprob = 20;
                default: wprob = 50;
            endcase
            r[0]  = ($urandom_range(0, 299) == 0);
            r[1]  = ($urandom_range(0, 299) == 0);
            we[0] = ($urandom_range(0, 99) < wprob);
            we[1] = ($urandom_range(0, 99) < wprob);
            re[0] = ($urandom_range(0, 99) < 100 - wprob);
            re[1] = ($urandom_range(0, 99) < 100 - wprob);
            cycle(r, we, re, word_t'($urandom), word_t'($urandom));
        end

        cycle(2'b00, 2'b00, 2'b00, '0, '0);
        @(posedge clk);
        #2;
        chk("scoreboard_drain", 0, 32'(expq[0].size() + expq[1].size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, data word width in bits (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, number of entries (>=2, not required to be a power of two).
REQ-003 SHALL have parameter AF_LEVEL, default FIFO_DEPTH-1, occupancy at or above which almostfull asserts (1..FIFO_DEPTH-1).
REQ-004 SHALL have parameter AE_LEVEL, default 1, occupancy at or below which almostempty asserts (1..FIFO_DEPTH-1).
REQ-005 SHALL have parameter FWFT, default 0; 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port data_in  input  FIFO_WIDTH  write data.
REQ-009 SHALL have port wr_en  input  1  write request.
REQ-010 SHALL have port rd_en  input  1  read request.
REQ-011 SHALL have port data_out  output  FIFO_WIDTH  read data.
REQ-012 SHALL have port wr_ack  output  1  registered; previous-cycle write accepted.
REQ-013 SHALL have port overflow  output  1  registered; previous-cycle write rejected because full.
REQ-014 SHALL have port underflow  output  1  registered; previous-cycle read rejected because empty.
REQ-015 SHALL have ports full, empty, almostfull, almostempty  output  1 each  combinational decodes of count.
REQ-016 SHALL have port count  output  $clog2(FIFO_DEPTH+1)  current occupancy.

Function
REQ-017 SHALL accept a write when wr_en=1 and full=0: store data_in at wr_ptr, advance wr_ptr, wr_ack=1 next cycle, overflow=0.
REQ-018 SHALL reject a write when wr_en=1 and full=1: memory/pointer unchanged, overflow=1 next cycle, wr_ack=0.
REQ-019 SHALL drive wr_ack=0 and overflow=0 in any cycle following wr_en=0.
REQ-020 SHALL accept a read when rd_en=1 and empty=0: advance rd_ptr; FWFT=0: data_out <= mem[rd_ptr] at the same edge (1-cycle latency); underflow=0.
REQ-021 SHALL reject a read when rd_en=1 and empty=1: pointer/data_out unchanged, underflow=1 next cycle; underflow=0 following any other cycle.
REQ-022 SHALL, FWFT=0, hold data_out between accepted reads.
REQ-023 SHALL, FWFT=1, drive data_out = mem[rd_ptr] combinationally whenever empty=0 (0 when empty); rd_en acknowledges the presented word.
REQ-024 SHALL wrap each pointer from FIFO_DEPTH-1 to 0.
REQ-025 SHALL, on simultaneous wr_en and rd_en with 0<count<FIFO_DEPTH, perform both and leave count unchanged.
REQ-026 SHALL, on simultaneous wr_en and rd_en when full, perform the read only, reject the write (overflow=1), count decrements.
REQ-027 SHALL, on simultaneous wr_en and rd_en when empty, perform the write only, reject the read (underflow=1), count increments; written word not readable until next cycle.
REQ-028 SHALL update count +1 per accepted write, -1 per accepted read, never outside 0..FIFO_DEPTH.
REQ-029 SHALL decode full=(count==FIFO_DEPTH), empty=(count==0).
REQ-030 SHALL decode almostfull=(count>=AF_LEVEL)&&!full, almostempty=(count<=AE_LEVEL)&&!empty.

Reset
REQ-031 SHALL, on rst=1 at a rising edge, clear wr_ptr, rd_ptr, count, wr_ack, overflow, underflow to 0 and (FWFT=0) data_out to 0; empty=1, full=0, almostfull=0, almostempty=0 afterward.
REQ-032 SHALL give rst priority over wr_en/rd_en in the same cycle: no write stored, no flags raised.
REQ-033 SHALL NOT require clearing memory contents on reset; stale entries SHALL never be readable.

Verification
REQ-034 Defaults, rst 1 cycle, write 8 words 0x0001..0x0008 -> wr_ack=1 each cycle, almostfull with count=7, full with count=8; 9th write -> overflow=1, wr_ack=0.
REQ-035 Full FIFO, 8 reads (FWFT=0) -> data_out 0x0001..0x0008 one cycle after each rd_en, empty after last; 9th read -> underflow=1, data_out holds 0x0008.
REQ-036 FIFO_DEPTH=5, 12 write+read pairs at count=2 -> count stays 2, data in order across pointer wrap.
REQ-037 Empty FIFO, wr_en=rd_en=1 data 0xA5A5 -> wr_ack=1, underflow=1, count=1; full FIFO same stimulus -> overflow=1, count=7.
REQ-038 FWFT=1, write 0x1234 -> data_out=0x1234 the cycle after the write with rd_en=0; rd_en=1 -> empty=1 next cycle.
REQ-039 rst=1 with count=4 and wr_en=1 -> next cycle count=0, empty=1, wr_ack=0, overflow=0, data_out=0.
